// File: rtl/control_unit_pkg.sv
// Shared definitions for the Mini SRC control unit: control-strobe bit
// positions, opcode values, sequencer states and the opcode-class decoder.
package control_unit_pkg;

  localparam int CTRL_BITS = 28;

  localparam int PC_OUT              = 0;
  localparam int ZLO_OUT             = 1;
  localparam int ZHI_OUT             = 2;
  localparam int HI_OUT              = 3;
  localparam int LO_OUT              = 4;
  localparam int MDR_OUT             = 5;
  localparam int INPORT_OUT          = 6;
  localparam int C_SIGN_EXTENDED_OUT = 7;
  localparam int R_OUT               = 8;
  localparam int BA_OUT              = 9;
  localparam int MAR_ENABLE          = 10;
  localparam int Z_ENABLE            = 11;
  localparam int LO_ENABLE           = 12;
  localparam int HI_ENABLE           = 13;
  localparam int PC_ENABLE           = 14;
  localparam int MDR_ENABLE          = 15;
  localparam int READ                = 16;
  localparam int RAM_WRITE           = 17;
  localparam int IR_ENABLE           = 18;
  localparam int Y_ENABLE            = 19;
  localparam int PC_INCREMENT        = 20;
  localparam int R_IN                = 21;
  localparam int GRA                 = 22;
  localparam int GRB                 = 23;
  localparam int GRC                 = 24;
  localparam int CON_ENABLE          = 25;
  localparam int OUTPORT_ENABLE      = 26;
  localparam int R15_ENABLE          = 27;

  localparam logic [4:0] OP_LD         = 5'b00000;
  localparam logic [4:0] OP_LDI        = 5'b00001;
  localparam logic [4:0] OP_ST         = 5'b00010;
  localparam logic [4:0] OP_ALU_FIRST  = 5'b00011;
  localparam logic [4:0] OP_ALU_LAST   = 5'b01011;
  localparam logic [4:0] OP_ALUI_FIRST = 5'b01100;
  localparam logic [4:0] OP_ALUI_LAST  = 5'b01110;
  localparam logic [4:0] OP_BR         = 5'b10011;
  localparam logic [4:0] OP_IN         = 5'b10110;
  localparam logic [4:0] OP_OUT        = 5'b10111;
  localparam logic [4:0] OP_MFHI       = 5'b11000;
  localparam logic [4:0] OP_MFLO       = 5'b11001;
  localparam logic [4:0] OP_NOP        = 5'b11010;
  localparam logic [4:0] OP_HALT       = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALTED
  } state_e;

  typedef enum logic [3:0] {
    CLS_LD, CLS_LDI, CLS_ST, CLS_ALU_R, CLS_ALU_I, CLS_BR, CLS_IN, CLS_OUT,
    CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } instr_cls_e;

  // Collapses the opcode space into the handful of step sequences the
  // sequencer actually distinguishes.
  function automatic instr_cls_e decode_op(input logic [4:0] op);
    decode_op = CLS_ILLEGAL;
    if (op >= OP_ALU_FIRST && op <= OP_ALU_LAST) begin
      decode_op = CLS_ALU_R;
    end else if (op >= OP_ALUI_FIRST && op <= OP_ALUI_LAST) begin
      decode_op = CLS_ALU_I;
    end else begin
      case (op)
        OP_LD:   decode_op = CLS_LD;
        OP_LDI:  decode_op = CLS_LDI;
        OP_ST:   decode_op = CLS_ST;
        OP_BR:   decode_op = CLS_BR;
        OP_IN:   decode_op = CLS_IN;
        OP_OUT:  decode_op = CLS_OUT;
        OP_MFHI: decode_op = CLS_MFHI;
        OP_MFLO: decode_op = CLS_MFLO;
        OP_NOP:  decode_op = CLS_NOP;
        OP_HALT: decode_op = CLS_HALT;
        default: decode_op = CLS_ILLEGAL;
      endcase
    end
  endfunction

endpackage

// File: rtl/control_unit.sv
// Mini SRC control sequencer: three fetch steps followed by opcode-specific
// execute steps, one strobe set per clock.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int CTRL_W = CTRL_BITS
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       ir,
  input  logic              con_ff,
  output logic [CTRL_W-1:0] ctrl,
  output logic              run,
  output logic              done,
  output logic              illegal
);

  state_e     state_q, state_d;
  instr_cls_e cls;
  logic       fin;
  logic       halt_go;
  logic       unused_ir;

  assign cls       = decode_op(ir[31:27]);
  assign unused_ir = ^ir[26:0];
  assign run       = (state_q != ST_RST) && (state_q != ST_HALTED);

  // NOTE: state register uses non-blocking assignment; all decode below is
  // purely combinational with every output defaulted first, so no latches.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_RST;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    done    = 1'b0;
    illegal = 1'b0;
    fin     = 1'b1;  // unexpected step/class combinations fall back to fetch
    halt_go = 1'b0;
    case (state_q)
      ST_RST:    state_d = ST_T0;
      ST_HALTED: state_d = ST_HALTED;
      ST_T0: begin
        ctrl[PC_OUT] = 1'b1; ctrl[MAR_ENABLE] = 1'b1;
        ctrl[PC_INCREMENT] = 1'b1; ctrl[Z_ENABLE] = 1'b1;
        state_d = ST_T1;
      end
      ST_T1: begin
        ctrl[ZLO_OUT] = 1'b1; ctrl[PC_ENABLE] = 1'b1;
        ctrl[READ] = 1'b1; ctrl[MDR_ENABLE] = 1'b1;
        state_d = ST_T2;
      end
      ST_T2: begin
        ctrl[MDR_OUT] = 1'b1; ctrl[IR_ENABLE] = 1'b1;
        state_d = ST_T3;
      end
      default: begin
        case (cls)
          CLS_LD, CLS_LDI, CLS_ST: begin
            case (state_q)
              ST_T3: begin
                ctrl[GRB] = 1'b1; ctrl[BA_OUT] = 1'b1; ctrl[Y_ENABLE] = 1'b1;
                fin = 1'b0;
              end
              ST_T4: begin
                ctrl[C_SIGN_EXTENDED_OUT] = 1'b1; ctrl[Z_ENABLE] = 1'b1;
                fin = 1'b0;
              end
              ST_T5: begin
                ctrl[ZLO_OUT] = 1'b1;
                if (cls == CLS_LDI) begin
                  ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; done = 1'b1;
                end else begin
                  ctrl[MAR_ENABLE] = 1'b1; fin = 1'b0;
                end
              end
              ST_T6: if (cls != CLS_LDI) begin
                ctrl[MDR_ENABLE] = 1'b1;
                if (cls == CLS_LD) ctrl[READ] = 1'b1;
                else begin ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; end
                fin = 1'b0;
              end
              ST_T7: if (cls != CLS_LDI) begin
                if (cls == CLS_LD) begin
                  ctrl[MDR_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1;
                end else begin
                  ctrl[RAM_WRITE] = 1'b1;
                end
                done = 1'b1;
              end
              default: ;
            endcase
          end
          CLS_ALU_R, CLS_ALU_I: begin
            case (state_q)
              ST_T3: begin
                ctrl[GRB] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[Y_ENABLE] = 1'b1;
                fin = 1'b0;
              end
              ST_T4: begin
                if (cls == CLS_ALU_R) begin
                  ctrl[GRC] = 1'b1; ctrl[R_OUT] = 1'b1;
                end else begin
                  ctrl[C_SIGN_EXTENDED_OUT] = 1'b1;
                end
                ctrl[Z_ENABLE] = 1'b1;
                fin = 1'b0;
              end
              ST_T5: begin
                ctrl[ZLO_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1;
                done = 1'b1;
              end
              default: ;
            endcase
          end
          CLS_BR: begin
            case (state_q)
              ST_T3: begin
                ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[CON_ENABLE] = 1'b1;
                fin = 1'b0;
              end
              ST_T4: begin
                ctrl[PC_OUT] = 1'b1; ctrl[Y_ENABLE] = 1'b1;
                fin = 1'b0;
              end
              ST_T5: begin
                ctrl[C_SIGN_EXTENDED_OUT] = 1'b1; ctrl[Z_ENABLE] = 1'b1;
                fin = 1'b0;
              end
              ST_T6: begin
                if (con_ff) begin
                  ctrl[ZLO_OUT] = 1'b1; ctrl[PC_ENABLE] = 1'b1;
                end
                done = 1'b1;
              end
              default: ;
            endcase
          end
          default: if (state_q == ST_T3) begin
            case (cls)
              CLS_IN:   begin ctrl[INPORT_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; end
              CLS_OUT:  begin ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[OUTPORT_ENABLE] = 1'b1; end
              CLS_MFHI: begin ctrl[HI_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; end
              CLS_MFLO: begin ctrl[LO_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; end
              default: ;
            endcase
            done    = (cls != CLS_HALT);
            illegal = (cls == CLS_ILLEGAL);
            halt_go = (cls == CLS_HALT);
          end
        endcase
        if (halt_go)  state_d = ST_HALTED;
        else if (fin) state_d = ST_T0;
        else          state_d = state_e'(state_q + 4'd1);
      end
    endcase
  end

endmodule
